// File: rtl/vc_skid_reg.sv
// vc_skid_reg: two-entry val/rdy pipeline register with a skid slot, fully registered on both sides
module vc_skid_reg #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg,
    output logic [1:0]         count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] main_q, main_d;
    logic [p_nbits-1:0] skid_q, skid_d;
    logic               enq_go, deq_go;

    // Outputs depend only on state and reset, so no input reaches an output combinationally.
    assign enq_rdy = !reset && (state_q != FULL);
    assign deq_val = (state_q != EMPTY);
    assign deq_msg = main_q;
    assign count   = state_q;
    assign enq_go  = enq_val && enq_rdy;
    assign deq_go  = deq_val && deq_rdy;

    // Next state and data movement; main always holds the oldest message, skid the younger one.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (enq_go) begin
                    main_d  = enq_msg;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (enq_go && deq_go) begin
                    main_d = enq_msg;
                end else if (enq_go) begin
                    skid_d  = enq_msg;
                    state_d = FULL;
                end else if (deq_go) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deq_go) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; reset discards any held messages.
    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Data registers carry no reset; their contents are ignored while the state says empty.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

`ifndef SYNTHESIS
    // Handshake inputs must be known outside reset and the spare state encoding must never appear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(enq_val)) else $error("vc_skid_reg: enq_val is X");
            assert (!$isunknown(deq_rdy)) else $error("vc_skid_reg: deq_rdy is X");
        end
        assert (state_q != 2'd3) else $error("vc_skid_reg: illegal state encoding");
    end
`endif
endmodule

// File: tb/tb_vc_skid_reg.sv
// tb_vc_skid_reg: scoreboard bench for vc_skid_reg driving directed and random handshakes
module tb_vc_skid_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enq_val = 1'b0;
    logic        enq_rdy;
    logic [31:0] enq_msg = '0;
    logic        deq_val;
    logic        deq_rdy = 1'b0;
    logic [31:0] deq_msg;
    logic [1:0]  count;

    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    bit          armed = 1'b0;

    vc_skid_reg #(.p_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg(enq_msg),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from just after a negedge, check outputs against the queue model, advance to the next negedge.
    task automatic step(input logic r, input logic ev, input logic [31:0] em, input logic dr);
        bit e_go, d_go;
        reset = r;
        enq_val = ev;
        enq_msg = em;
        deq_rdy = dr;
        #1;
        check("enq_rdy", 32'(enq_rdy), 32'(!r && sb.size() < 2));
        if (armed) begin
            check("deq_val", 32'(deq_val), 32'(sb.size() > 0));
            check("count", 32'(count), 32'(sb.size()));
            if (sb.size() > 0) check("deq_msg", deq_msg, sb[0]);
        end
        e_go = ev && !r && sb.size() < 2;
        d_go = dr && !r && sb.size() > 0;
        @(posedge clk);
        if (d_go) void'(sb.pop_front());
        if (e_go) sb.push_back(em);
        if (r) sb.delete();
        armed = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        step(1, 1, 32'hDEAD, 0);
        step(1, 1, 32'hDEAD, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        step(0, 1, 32'h11, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        for (int i = 1; i <= 8; i++) step(0, 1, 32'(i), 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        step(0, 1, 32'hA1, 0);
        step(0, 1, 32'hA2, 0);
        step(0, 1, 32'hA3, 0);
        step(0, 1, 32'hA3, 0);
        step(0, 1, 32'hA3, 1);
        step(0, 1, 32'hA3, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        step(0, 1, 32'h55, 0);
        step(0, 1, 32'h66, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        step(0, 1, 32'hB1, 0);
        step(0, 1, 32'hB2, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 32'hC1, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
